uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8: width of one stored byte.
REQ-002 Parameter ADDR_BITS, default 2: depth is 2**ADDR_BITS entries (4 at default).
REQ-003 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port wr, input, 1: push strobe, driven by the receiver's rx_done_tick (one-cycle pulse).
REQ-006 Port w_data, input, DATA_BITS: byte to push, driven by the receiver's dout.
REQ-007 Port rd, input, 1: pop strobe from rx_interface.
REQ-008 Port r_data, output, DATA_BITS: head-of-queue byte, first-word-fall-through.
REQ-009 Port empty, output, 1: queue holds zero entries; feeds rx_interface's rx_empty.
REQ-010 Port full, output, 1: queue holds 2**ADDR_BITS entries.
REQ-011 Port count, output, ADDR_BITS+1: current number of stored entries.
REQ-012 Port overflow, output, 1: sticky flag, a push was dropped.

Function
REQ-013 The block SHALL sit between rx_module and rx_interface, buffering received bytes so ALU frames survive back-to-back reception.
REQ-014 Push (wr=1, full=0) SHALL write w_data at the write pointer and advance it by one, modulo depth.
REQ-015 Pop (rd=1, empty=0) SHALL advance the read pointer by one, modulo depth; r_data shows the next entry in the following cycle.
REQ-016 r_data SHALL equal the entry at the read pointer whenever empty=0; value is don't-care when empty=1.
REQ-017 Push-to-visibility latency SHALL be one cycle: a byte pushed at edge N appears on r_data with empty=0 after edge N.
REQ-018 empty, full and count SHALL be registered and updated on the same edge as the pointers.
REQ-019 Simultaneous wr and rd with 0<count<depth SHALL do both; count is unchanged.
REQ-020 Simultaneous wr and rd when full SHALL do both; full stays 1 and no overflow is flagged.
REQ-021 Simultaneous wr and rd when empty SHALL do the push only; the rd is ignored.
REQ-022 rd when empty (no wr) SHALL be ignored: pointers and count unchanged, no error flag.
REQ-023 wr when full (no rd) SHALL drop the byte, leave the contents unchanged and set overflow to 1.
REQ-024 overflow SHALL remain 1 until reset.
REQ-025 Pointers SHALL be ADDR_BITS wide and wrap naturally; full/empty SHALL be derived from count, not from pointer equality alone.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for a clock edge, clear both pointers, set count=0, empty=1, full=0 and overflow=0.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 Reset asserted mid-burst SHALL discard all stored bytes; the first push after deassertion lands in entry 0.

Structure
REQ-029 DATA_BITS and ADDR_BITS defaults SHALL live in the shared UART constants package used by rx_module and rx_interface.
REQ-030 The storage array SHALL be a separate sub-module, fifo_regfile: synchronous write, asynchronous read, no reset; pointer and flag control stay in uart_rx_fifo.

Verification
REQ-031 Reset, then push 0x35 ('5') -> one cycle later r_data=0x35, empty=0, count=1.
REQ-032 Push 0x35, 0x66, 0x31, 0x30 -> full=1, count=4; four pops return 0x35, 0x66, 0x31, 0x30 in order, then empty=1.
REQ-033 While full, push 0x2B ('+') without rd -> overflow=1, count=4, popped data unchanged; overflow stays 1 after draining.
REQ-034 While full, wr=1 with 0x73 and rd=1 in the same cycle -> count=4, no overflow; the fifth pop returns 0x73 (wrap-around checked).
REQ-035 While empty, wr=1 with 0x6F and rd=1 in the same cycle -> count=1, r_data=0x6F; a lone rd when empty leaves count=0.
REQ-036 Pulse reset asynchronously mid-cycle with count=3 -> empty=1, count=0 before the next edge; next push of 0x64 reads back 0x64.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants used by rx_module, rx_interface and the receive FIFO.
// Holds default byte width and FIFO address width plus the FIFO operation encoding.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_ADDR_BITS = 2;

    // Encoding matches the {push, pop} bit pair so it can be cast directly.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read, no reset.
// Ports: clk, we_i, waddr_i, wdata_i (write side); raddr_i -> rdata_o (read side).
module fifo_regfile #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between rx_module and rx_interface; first-word-fall-through output.
// Ports: clk, reset (async high), wr/w_data push, rd pop, r_data head,
// empty/full/count status, overflow sticky drop flag.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int ADDR_BITS = UART_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] w_data,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow
);

    localparam logic [ADDR_BITS:0] FULL_CNT = {1'b1, {ADDR_BITS{1'b0}}};

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;
    logic                 push, pop;
    fifo_op_e             op;

    // A push while full is still accepted when a pop frees the slot that cycle.
    // A pop while empty is ignored even if a push arrives with it.
    assign push = wr & (~full_q | rd);
    assign pop  = rd & ~empty_q;
    assign op   = fifo_op_e'({push, pop});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        unique case (op)
            OP_PUSH: begin
                wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
                count_d  = count_q + (ADDR_BITS+1)'(1);
            end
            OP_POP: begin
                rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
                count_d  = count_q - (ADDR_BITS+1)'(1);
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
                rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
            end
            OP_IDLE: begin
                count_d = count_q;
            end
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);
        ovf_d   = ovf_q | (wr & full_q & ~rd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    fifo_regfile #(
        .DATA_BITS(DATA_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) u_regfile (
        .clk    (clk),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(w_data),
        .raddr_i(rd_ptr_q),
        .rdata_o(r_data)
    );

    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus scoreboard of bytes,
// with hand-written sequences for reset state and asynchronous mid-cycle reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb[$];

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] d;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    uart_rx_fifo dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .w_data  (w_data),
        .rd      (rd),
        .r_data  (r_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic r, input logic [7:0] d,
                       input int c, input logic e, input logic f,
                       input logic o);
        vec_t v;
        v.wr = w; v.rd = r; v.d = d; v.cnt = c;
        v.emp = e; v.ful = f; v.ovf = o;
        tbl.push_back(v);
    endtask

    // Drive one cycle; scoreboard tracks accepted bytes and checks pop data.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic do_pop;
        logic do_push;
        @(negedge clk);
        wr = w;
        rd = r;
        w_data = d;
        #1;
        do_pop  = r && (sb.size() > 0);
        do_push = w && ((sb.size() < 4) || r);
        if (do_pop) chk("pop_data", 32'(r_data), 32'(sb[0]));
        @(posedge clk);
        #1;
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back(d);
        wr = 1'b0;
        rd = 1'b0;
        if (sb.size() > 0) chk("head", 32'(r_data), 32'(sb[0]));
    endtask

    task automatic chk_flags(input string tag, input int c, input logic e,
                             input logic f, input logic o);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_empty"}, 32'(empty), 32'(e));
        chk({tag, "_full"}, 32'(full), 32'(f));
        chk({tag, "_ovf"}, 32'(overflow), 32'(o));
    endtask

    initial begin
        // basic push / drain
        add(1, 0, 8'h35, 1, 0, 0, 0);
        add(1, 0, 8'h66, 2, 0, 0, 0);
        add(1, 0, 8'h31, 3, 0, 0, 0);
        add(1, 0, 8'h30, 4, 0, 1, 0);
        add(0, 1, 8'h00, 3, 0, 0, 0);
        add(0, 1, 8'h00, 2, 0, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 1, 0, 0);
        // lone rd when empty
        add(0, 1, 8'h00, 0, 1, 0, 0);
        // wr+rd when empty: push only
        add(1, 1, 8'h6F, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 1, 0, 0);
        // refill, then wr+rd while full
        add(1, 0, 8'h35, 1, 0, 0, 0);
        add(1, 0, 8'h66, 2, 0, 0, 0);
        add(1, 0, 8'h31, 3, 0, 0, 0);
        add(1, 0, 8'h30, 4, 0, 1, 0);
        add(1, 1, 8'h73, 4, 0, 1, 0);
        // push while full: dropped, overflow sticky
        add(1, 0, 8'h2B, 4, 0, 1, 1);
        add(0, 1, 8'h00, 3, 0, 0, 1);
        add(0, 1, 8'h00, 2, 0, 0, 1);
        add(0, 1, 8'h00, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 1, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset", 0, 1, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk_flags($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].emp,
                      tbl[i].ful, tbl[i].ovf);
        end

        // asynchronous reset mid-cycle with three bytes stored
        step(1, 0, 8'h01);
        step(1, 0, 8'h02);
        step(1, 0, 8'h03);
        chk_flags("pre_rst", 3, 0, 0, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_flags("async_rst", 0, 1, 0, 0);
        reset = 1'b0;
        sb.delete();
        step(1, 0, 8'h64);
        chk_flags("post_rst", 1, 0, 0, 0);
        chk("post_rst_data", 32'(r_data), 32'h64);
        step(0, 1, 8'h00);
        chk_flags("post_rst_pop", 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
